// File: rtl/stable_scan_pkg.sv
// Shared defaults, FSM state type and helpers for the stable-value scanner.
package stable_scan_pkg;

   localparam int unsigned W_DEFAULT        = 14;
   localparam int unsigned NCH_DEFAULT      = 4;
   localparam logic [15:0] INTERVAL_DEFAULT = 16'h50DC;

   typedef enum logic {
      IDLE,
      SCAN
   } scan_state_e;

   // Width of a channel index; at least one bit so single-channel builds stay legal.
   function automatic int unsigned ch_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/stable_scan_ctrl_if.sv
// Stable-event handshake: the scanner presents (channel, value), the consumer accepts.
interface stable_scan_ctrl_if
   import stable_scan_pkg::*;
#(
   parameter int unsigned W   = W_DEFAULT,
   parameter int unsigned NCH = NCH_DEFAULT
);

   localparam int unsigned CH_W = ch_width(NCH);

   logic            out_valid;
   logic            out_ready;
   logic [CH_W-1:0] out_ch;
   logic [W-1:0]    out_num;

   modport master (
      output out_valid,
      output out_ch,
      output out_num,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_ch,
      input  out_num,
      output out_ready
   );

endinterface

// File: rtl/scan_tick_gen.sv
// Free-running interval counter; emits a one-cycle tick on the last count of each period.
module scan_tick_gen
   import stable_scan_pkg::*;
#(
   parameter logic [15:0] INTERVAL = INTERVAL_DEFAULT
) (
   input  logic clk,
   input  logic clr,
   output logic tick
);

   logic [15:0] cnt_q;

   // Tick is suppressed while clearing so a reset edge never starts a scan.
   always_comb begin
      tick = !clr && (cnt_q == INTERVAL - 16'd1);
   end

   // Count up, wrap to zero at the end of the period.
   always_ff @(posedge clk) begin
      if (clr || tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

endmodule

// File: rtl/stable_scan_ctrl.sv
// Periodically samples NCH channels through one shared comparator, declares a value
// stable on its third equal sample and hands out stable events round-robin.
module stable_scan_ctrl
   import stable_scan_pkg::*;
#(
   parameter int unsigned W        = W_DEFAULT,
   parameter int unsigned NCH      = NCH_DEFAULT,
   parameter logic [15:0] INTERVAL = INTERVAL_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               locked,
   input  logic [NCH*W-1:0]   num,
   output logic [NCH-1:0]     stable,
   stable_scan_ctrl_if.master ev
);

   localparam int unsigned     CH_W    = ch_width(NCH);
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);

   logic clr;
   logic tick;

   scan_state_e     state_q, state_d;
   logic [CH_W-1:0] idx_q, idx_d;
   logic            scan_en;

   logic [NCH-1:0][W-1:0] num_arr;
   logic [NCH-1:0][W-1:0] ref_q, ref_d;
   logic [NCH-1:0]        stage_q, stage_d;
   logic [NCH-1:0]        stable_q, stable_d;
   logic [NCH-1:0]        pend_q, pend_d;
   logic [NCH-1:0]        drop;
   logic [NCH-1:0]        cand;

   logic            out_valid_q, out_valid_d;
   logic [CH_W-1:0] out_ch_q, out_ch_d;
   logic [W-1:0]    out_num_q, out_num_d;
   logic [CH_W-1:0] rr_q, rr_d;

   logic [W-1:0]    cur_num;
   logic            same;
   logic            presented_here;
   logic            found;
   logic [CH_W-1:0] sel;
   logic [CH_W-1:0] c;

   assign clr     = rst | locked;
   assign num_arr = num;

   scan_tick_gen #(
      .INTERVAL (INTERVAL)
   ) u_tick_gen (
      .clk  (clk),
      .clr  (clr),
      .tick (tick)
   );

   // The single comparator always looks at the channel under the scan index.
   assign cur_num        = num_arr[idx_q];
   assign same           = (cur_num == ref_q[idx_q]);
   assign presented_here = out_valid_q && (out_ch_q == idx_q);

   // Scan sequencer: wait for a tick, then walk channels 0..NCH-1 one per cycle.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      scan_en = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (tick) begin
               state_d = SCAN;
               idx_d   = '0;
            end
         end
         SCAN: begin
            scan_en = 1'b1;
            if (idx_q == LAST_CH) begin
               state_d = IDLE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + CH_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // Per-channel qualification; accept clears pending first so a same-cycle set wins.
   always_comb begin
      ref_d    = ref_q;
      stage_d  = stage_q;
      stable_d = stable_q;
      pend_d   = pend_q;
      drop     = '0;
      if (out_valid_q && ev.out_ready) begin
         pend_d[out_ch_q] = 1'b0;
      end
      if (scan_en) begin
         if (!same) begin
            ref_d[idx_q]    = cur_num;
            stage_d[idx_q]  = 1'b0;
            stable_d[idx_q] = 1'b0;
            // A presented event is never withdrawn, so its pending bit is left alone.
            if (!presented_here) begin
               pend_d[idx_q] = 1'b0;
               drop[idx_q]   = 1'b1;
            end
         end else if (!stage_q[idx_q]) begin
            stage_d[idx_q] = 1'b1;
         end else begin
            stable_d[idx_q] = 1'b1;
            if (!stable_q[idx_q]) begin
               pend_d[idx_q] = 1'b1;
            end
         end
      end
   end

   // Round-robin presenter; channels invalidated this cycle are not eligible.
   always_comb begin
      cand        = pend_q & ~drop;
      found       = 1'b0;
      sel         = '0;
      c           = '0;
      out_valid_d = out_valid_q;
      out_ch_d    = out_ch_q;
      out_num_d   = out_num_q;
      rr_d        = rr_q;
      for (int k = 0; k < int'(NCH); k++) begin
         c = rr_q + CH_W'(k);
         if (!found && cand[c]) begin
            found = 1'b1;
            sel   = c;
         end
      end
      if (out_valid_q) begin
         if (ev.out_ready) begin
            out_valid_d = 1'b0;
            rr_d        = out_ch_q + CH_W'(1);
         end
      end else if (found) begin
         out_valid_d = 1'b1;
         out_ch_d    = sel;
         out_num_d   = ref_q[sel];
      end
   end

   // State registers; rst and locked both abort everything on the next edge.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         ref_q       <= '0;
         stage_q     <= '0;
         stable_q    <= '0;
         pend_q      <= '0;
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         out_num_q   <= '0;
         rr_q        <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         ref_q       <= ref_d;
         stage_q     <= stage_d;
         stable_q    <= stable_d;
         pend_q      <= pend_d;
         out_valid_q <= out_valid_d;
         out_ch_q    <= out_ch_d;
         out_num_q   <= out_num_d;
         rr_q        <= rr_d;
      end
   end

   assign stable       = stable_q;
   assign ev.out_valid = out_valid_q;
   assign ev.out_ch    = out_ch_q;
   assign ev.out_num   = out_num_q;

endmodule

// File: tb/tb_stable_scan_ctrl.sv
// Directed bench for stable_scan_ctrl with INTERVAL=8, NCH=4, W=14.
// Edge Ek is the k-th rising edge after rst/locked is released (E0 first).
// Scan n processes channel i at edge 8*n + i.
module tb_stable_scan_ctrl;

   localparam int unsigned W   = 14;
   localparam int unsigned NCH = 4;

   logic               clk = 1'b0;
   logic               rst;
   logic               locked;
   logic [NCH*W-1:0]   num;
   logic [NCH-1:0]     stable;

   int n_chk  = 0;
   int n_pass = 0;
   int ecnt   = 0;

   logic [15:0] log_ch[$];
   logic [15:0] log_num[$];

   stable_scan_ctrl_if #(.W(W), .NCH(NCH)) ev ();

   stable_scan_ctrl #(
      .W        (W),
      .NCH      (NCH),
      .INTERVAL (16'd8)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .locked (locked),
      .num    (num),
      .stable (stable),
      .ev     (ev)
   );

   always #5 clk = ~clk;

   // Edge index relative to the last clear.
   always @(posedge clk) ecnt <= (rst || locked) ? -1 : ecnt + 1;

   // Record every accepted event, sampled half a cycle before the accepting edge.
   always @(negedge clk) begin
      if (!rst && !locked && ev.out_valid && ev.out_ready) begin
         log_ch.push_back(16'(ev.out_ch));
         log_num.push_back(16'(ev.out_num));
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_num(input logic [W-1:0] n0, input logic [W-1:0] n1,
                          input logic [W-1:0] n2, input logic [W-1:0] n3);
      num = {n3, n2, n1, n0};
   endtask

   task automatic wait_edge(input int e);
      int guard = 0;
      while (ecnt != e && guard < 500) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (ecnt != e) check("wait_edge", 32'(ecnt), 32'(e));
   endtask

   task automatic check_out(input string tag, input logic v, input logic [1:0] ch,
                            input logic [W-1:0] n);
      check({tag, "_valid"}, 32'(ev.out_valid), 32'(v));
      check({tag, "_ch"}, 32'(ev.out_ch), 32'(ch));
      check({tag, "_num"}, 32'(ev.out_num), 32'(n));
   endtask

   task automatic apply_reset();
      rst    = 1'b1;
      locked = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_stable", 32'(stable), 32'h0);
      check_out("rst_out", 1'b0, 2'd0, '0);
      rst = 1'b0;
      log_ch.delete();
      log_num.delete();
   endtask

   initial begin
      rst          = 1'b1;
      locked       = 1'b0;
      num          = '0;
      ev.out_ready = 1'b1;

      // Constant 0x1234 on ch0, zeros elsewhere, always ready.
      set_num(14'h1234, 0, 0, 0);
      apply_reset();
      wait_edge(16); check("t1_stable_e16", 32'(stable), 32'h0);
      wait_edge(17); check("t1_stable_e17", 32'(stable), 32'h2);
      wait_edge(18); check_out("t1_e18", 1'b1, 2'd1, 14'h0);
      wait_edge(23); check("t1_stable_e23", 32'(stable), 32'hE);
      wait_edge(24); check("t1_stable_e24", 32'(stable), 32'hF);
      wait_edge(25); check_out("t1_e25", 1'b1, 2'd0, 14'h1234);
      wait_edge(30);
      check("t1_nev", 32'(log_ch.size()), 32'd4);
      if (log_ch.size() == 4) begin
         check("t1_ev0_ch", 32'(log_ch[0]), 32'd1);
         check("t1_ev1_ch", 32'(log_ch[1]), 32'd2);
         check("t1_ev2_ch", 32'(log_ch[2]), 32'd3);
         check("t1_ev2_num", 32'(log_num[2]), 32'h0);
         check("t1_ev3_ch", 32'(log_ch[3]), 32'd0);
         check("t1_ev3_num", 32'(log_num[3]), 32'h1234);
      end

      // ch0 changes to 0x1235 between the second and third tick.
      set_num(14'h1234, 0, 0, 0);
      apply_reset();
      wait_edge(16); set_num(14'h1235, 0, 0, 0);
      wait_edge(24); check("t2_s0_e24", 32'(stable[0]), 32'h0);
      wait_edge(39); check("t2_s0_e39", 32'(stable[0]), 32'h0);
      wait_edge(40); check("t2_s0_e40", 32'(stable[0]), 32'h1);
      wait_edge(41); check_out("t2_e41", 1'b1, 2'd0, 14'h1235);

      // Backpressure: ch1/ch2/ch3 qualify in one scan, consumer stalls.
      set_num(14'h1234, 0, 0, 0);
      ev.out_ready = 1'b0;
      apply_reset();
      wait_edge(18); check_out("t3_e18", 1'b1, 2'd1, 14'h0);
      wait_edge(30); check_out("t3_e30", 1'b1, 2'd1, 14'h0);
      wait_edge(38); check_out("t3_e38", 1'b1, 2'd1, 14'h0);
      ev.out_ready = 1'b1;
      wait_edge(39); check("t3_valid_e39", 32'(ev.out_valid), 32'h0);
      wait_edge(40); check_out("t3_e40", 1'b1, 2'd2, 14'h0);
      wait_edge(41); check("t3_rr_e41", 32'(dut.rr_q), 32'd3);
      wait_edge(42); check_out("t3_e42", 1'b1, 2'd3, 14'h0);

      // ch2 pending but not presented, then its input changes.
      set_num(14'h1234, 0, 0, 0);
      ev.out_ready = 1'b0;
      apply_reset();
      wait_edge(19); set_num(14'h1234, 0, 14'h0055, 0);
      wait_edge(25); check("t4_s2_e25", 32'(stable[2]), 32'h1);
      wait_edge(26); check("t4_s2_e26", 32'(stable[2]), 32'h0);
      wait_edge(30); ev.out_ready = 1'b1;
      wait_edge(40);
      check("t4_nev", 32'(log_ch.size()), 32'd3);
      if (log_ch.size() == 3) begin
         check("t4_ev0_ch", 32'(log_ch[0]), 32'd1);
         check("t4_ev1_ch", 32'(log_ch[1]), 32'd3);
         check("t4_ev2_ch", 32'(log_ch[2]), 32'd0);
         check("t4_ev2_num", 32'(log_num[2]), 32'h1234);
      end

      // locked pulse mid-scan while an event is presented.
      set_num(14'h1234, 0, 0, 0);
      ev.out_ready = 1'b0;
      apply_reset();
      wait_edge(24);
      check("t5_valid_e24", 32'(ev.out_valid), 32'h1);
      locked = 1'b1;
      @(posedge clk);
      #1;
      check("t5_stable_lk", 32'(stable), 32'h0);
      check_out("t5_lk", 1'b0, 2'd0, '0);
      check("t5_cnt_lk", 32'(dut.u_tick_gen.cnt_q), 32'h0);
      locked = 1'b0;
      wait_edge(17); check("t5_stable_e17", 32'(stable), 32'h2);
      wait_edge(18); check_out("t5_e18", 1'b1, 2'd1, 14'h0);
      wait_edge(23); check("t5_stable_e23", 32'(stable), 32'hE);
      wait_edge(24); check("t5_stable_e24", 32'(stable), 32'hF);

      // rst while ch0 is presented and stable.
      set_num(14'h1234, 0, 0, 0);
      ev.out_ready = 1'b1;
      apply_reset();
      wait_edge(23); ev.out_ready = 1'b0;
      wait_edge(27); check_out("t6_e27", 1'b1, 2'd0, 14'h1234);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("t6_valid_rst", 32'(ev.out_valid), 32'h0);
      check("t6_stable_rst", 32'(stable), 32'h0);
      rst          = 1'b0;
      ev.out_ready = 1'b1;
      log_ch.delete();
      log_num.delete();
      wait_edge(23);
      check("t6_s0_e23", 32'(stable), 32'hE);
      check("t6_nev_e23", 32'(log_ch.size()), 32'd3);
      wait_edge(25); check_out("t6_e25", 1'b1, 2'd0, 14'h1234);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
